// File: rtl/conv_stream_ctrl_pkg.sv
// Shared types and sizing helpers for the streaming convolution controller.
package conv_stream_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Full-precision accumulator width: product width plus growth for all taps.
  function automatic int unsigned acc_width(input int unsigned data_width,
                                            input int unsigned k_size);
    return 2 * data_width + $clog2(k_size * k_size);
  endfunction

  // Number of results produced by one frame.
  function automatic int unsigned out_count(input int unsigned img_w,
                                            input int unsigned img_h,
                                            input int unsigned k_size,
                                            input int unsigned stride);
    return ((img_w - k_size) / stride + 1) * ((img_h - k_size) / stride + 1);
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_stream_ctrl_if.sv
// Pixel input and result output streams with valid/ready handshakes.
interface conv_stream_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/conv_window_buf.sv
// Line buffers plus K x K sliding window; exposes the window as it will be
// after the pixel currently presented is pushed.
module conv_window_buf
  import conv_stream_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned K_SIZE     = 3,
  parameter int unsigned DATA_WIDTH = 16,
  localparam int unsigned CW        = idx_width(IMG_W),
  localparam int unsigned NTAP      = K_SIZE * K_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [CW-1:0]                col,
  input  logic signed [DATA_WIDTH-1:0] pixel,
  output logic signed [DATA_WIDTH-1:0] win_c [NTAP]
);

  localparam int unsigned NLB = (K_SIZE > 1) ? K_SIZE - 1 : 1;

  logic signed [DATA_WIDTH-1:0] lb    [NLB][IMG_W];
  logic signed [DATA_WIDTH-1:0] win_q [NTAP];
  logic signed [DATA_WIDTH-1:0] col_c [K_SIZE];

  // Incoming column, oldest row first: line buffers above, live pixel at the bottom.
  always_comb begin
    col_c[K_SIZE-1] = pixel;
    for (int unsigned i = 0; i < K_SIZE - 1; i++) begin
      col_c[i] = lb[K_SIZE-2-i][col];
    end
  end

  // Next window: shift every row one column left and append the new column.
  always_comb begin
    for (int unsigned i = 0; i < K_SIZE; i++) begin
      for (int unsigned j = 0; j < K_SIZE - 1; j++) begin
        win_c[i*K_SIZE+j] = win_q[i*K_SIZE+j+1];
      end
      win_c[i*K_SIZE+K_SIZE-1] = col_c[i];
    end
  end

  // Line buffer cascade and window registers advance on each accepted pixel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NLB; i++) begin
        for (int unsigned c = 0; c < IMG_W; c++) begin
          lb[i][c] <= '0;
        end
      end
      for (int unsigned t = 0; t < NTAP; t++) begin
        win_q[t] <= '0;
      end
    end else if (push) begin
      lb[0][col] <= pixel;
      for (int unsigned i = 1; i < K_SIZE - 1; i++) begin
        lb[i][col] <= lb[i-1][col];
      end
      for (int unsigned t = 0; t < NTAP; t++) begin
        win_q[t] <= win_c[t];
      end
    end
  end

endmodule

// File: rtl/conv_stream_ctrl.sv
// Streaming 2-D convolution: raster pixels in, saturated fixed-point results out.
module conv_stream_ctrl
  import conv_stream_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W      = 8,
  parameter int unsigned IMG_H      = 8,
  parameter int unsigned K_SIZE     = 3,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned Q          = 5,
  localparam int unsigned WA_W      = idx_width(K_SIZE * K_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  w_we,
  input  logic [WA_W-1:0]       w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  conv_stream_ctrl_if.slave     strm,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NTAP  = K_SIZE * K_SIZE;
  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, K_SIZE);
  localparam int unsigned OUT_N = out_count(IMG_W, IMG_H, K_SIZE, STRIDE);
  localparam int unsigned CW    = idx_width(IMG_W);
  localparam int unsigned RW    = idx_width(IMG_H);
  localparam int unsigned NW    = idx_width(OUT_N);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    ACC_W'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_e                        state, state_n;
  logic [CW-1:0]                 col;
  logic [RW-1:0]                 row;
  logic [NW-1:0]                 res_cnt;
  logic                          last_acked;
  logic signed [DATA_WIDTH-1:0]  wgt    [NTAP];
  logic signed [DATA_WIDTH-1:0]  win_c  [NTAP];
  logic signed [2*DATA_WIDTH-1:0] prod_c [NTAP];
  logic signed [ACC_W-1:0]       acc_c, shr_c;
  logic signed [DATA_WIDTH-1:0]  sat_c;
  logic accept_c, out_fire_c, last_pix_c, win_done_c;

  assign strm.in_ready = (state == ST_RUN) && (!strm.out_valid || strm.out_ready);
  assign accept_c      = strm.in_valid && strm.in_ready;
  assign out_fire_c    = strm.out_valid && strm.out_ready;
  assign last_pix_c    = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign win_done_c    = (32'(row) >= K_SIZE - 1) && (32'(col) >= K_SIZE - 1) &&
                         (((32'(row) - (K_SIZE - 1)) % STRIDE) == 32'd0) &&
                         (((32'(col) - (K_SIZE - 1)) % STRIDE) == 32'd0);

  conv_window_buf #(
    .IMG_W      (IMG_W),
    .K_SIZE     (K_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_win (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_c),
    .col   (col),
    .pixel (strm.in_data),
    .win_c (win_c)
  );

  // Frame sequencing; DRAIN also exits when the final result left during RUN.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_RUN;
      ST_RUN:   if (accept_c && last_pix_c) state_n = ST_DRAIN;
      ST_DRAIN: if (last_acked || (out_fire_c && strm.out_last)) state_n = ST_DONE;
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register with busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= (state_n == ST_DONE);
    end
  end

  // Raster position, result count and final-result bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      res_cnt    <= '0;
      last_acked <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      col        <= '0;
      row        <= '0;
      res_cnt    <= '0;
      last_acked <= 1'b0;
    end else begin
      if (accept_c) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (accept_c && win_done_c) res_cnt <= res_cnt + NW'(1);
      if (out_fire_c && strm.out_last) last_acked <= 1'b1;
    end
  end

  // Kernel weights, writable only between frames.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned t = 0; t < NTAP; t++) wgt[t] <= '0;
    end else if (state == ST_IDLE && w_we && (32'(w_addr) < NTAP)) begin
      wgt[w_addr] <= w_data;
    end
  end

  // Full-precision multiply-accumulate over the next window.
  always_comb begin
    acc_c = '0;
    for (int unsigned t = 0; t < NTAP; t++) begin
      prod_c[t] = (2*DATA_WIDTH)'(win_c[t]) * (2*DATA_WIDTH)'(wgt[t]);
      acc_c     = acc_c + ACC_W'(prod_c[t]);
    end
  end

  // Rescale by Q fractional bits and clamp to the signed output range.
  always_comb begin
    shr_c = acc_c >>> Q;
    if (shr_c > SAT_MAX)      sat_c = DATA_WIDTH'(SAT_MAX);
    else if (shr_c < SAT_MIN) sat_c = DATA_WIDTH'(SAT_MIN);
    else                      sat_c = DATA_WIDTH'(shr_c);
  end

  // Output holding register; loads only when the slot is free or draining.
  always_ff @(posedge clk) begin
    if (!rst) begin
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_last  <= 1'b0;
    end else if (accept_c && win_done_c) begin
      strm.out_valid <= 1'b1;
      strm.out_data  <= sat_c;
      strm.out_last  <= (res_cnt == NW'(OUT_N - 1));
    end else if (out_fire_c) begin
      strm.out_valid <= 1'b0;
      strm.out_last  <= 1'b0;
    end
  end

endmodule

// File: doc/conv_stream_ctrl.md
CONV_STREAM_CTRL -- requirements
Module: conv_stream_ctrl

Interface
REQ-001 Parameter IMG_W, default 8, image width in pixels (>= K_SIZE).
REQ-002 Parameter IMG_H, default 8, image height in pixels (>= K_SIZE).
REQ-003 Parameter K_SIZE, default 3, square kernel edge (>= 1).
REQ-004 Parameter STRIDE, default 1, horizontal and vertical window step (>= 1).
REQ-005 Parameter DATA_WIDTH, default 16, signed fixed-point pixel/weight/result width.
REQ-006 Parameter Q, default 5, fractional bits of all fixed-point values.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 start  in  1  one-cycle frame-start request; honoured only in IDLE.
REQ-010 w_we  in  1  weight write strobe; honoured only in IDLE.
REQ-011 w_addr  in  clog2(K_SIZE*K_SIZE)  row-major kernel tap index.
REQ-012 w_data  in  DATA_WIDTH  signed weight value.
REQ-013 in_data  in  DATA_WIDTH  pixel, raster order.
REQ-014 in_valid  in  1  in_data valid.
REQ-015 in_ready  out  1  block accepts in_data this cycle.
REQ-016 out_data  out  DATA_WIDTH  convolution result.
REQ-017 out_valid  out  1  out_data valid; held until accepted.
REQ-018 out_ready  in  1  downstream accepts out_data.
REQ-019 out_last  out  1  marks final result of the frame, qualified by out_valid.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 done  out  1  one-cycle pulse when the frame completes.

Function
REQ-022 States: IDLE, RUN, DRAIN, DONE; IDLE->RUN on start; RUN->DRAIN when pixel IMG_W*IMG_H-1 is accepted; DRAIN->DONE when the final result is accepted (out_valid & out_ready); DONE->IDLE after one cycle with done=1.
REQ-023 A pixel is accepted when in_valid & in_ready; in_ready = (state==RUN) & (!out_valid | out_ready).
REQ-024 Column counter wraps at IMG_W-1 and increments the row counter; both counters clear on start.
REQ-025 Accepted pixel (r,c) completes a window when r>=K_SIZE-1, c>=K_SIZE-1, (r-K_SIZE+1) mod STRIDE==0 and (c-K_SIZE+1) mod STRIDE==0.
REQ-026 The result for a completed window appears on out_data with out_valid=1 exactly one cycle after acceptance.
REQ-027 Result = sum over taps of window pixel times weight; full-precision accumulator of 2*DATA_WIDTH+clog2(K_SIZE*K_SIZE) bits.
REQ-028 The accumulator is arithmetically shifted right by Q and then saturated to signed DATA_WIDTH range.
REQ-029 The frame produces exactly ((IMG_W-K_SIZE)/STRIDE+1)*((IMG_H-K_SIZE)/STRIDE+1) results in raster order.
REQ-030 out_last=1 only with the final result of the frame.
REQ-031 With out_valid=1 and out_ready=0, out_data and out_last shall hold and no pixel shall be accepted.
REQ-032 start outside IDLE, and w_we outside IDLE, shall be ignored.
REQ-033 Weights persist across frames until rewritten.

Reset
REQ-034 While rst=0 at a clock edge: state=IDLE, counters=0, line buffers=0, weights=0, out_data=0, out_valid=0, out_last=0, in_ready=0, busy=0, done=0.
REQ-035 Reset asserted mid-frame shall abort the frame with no further outputs and no done pulse.

Structure
REQ-036 A shared package shall hold the state enumeration and the accumulator-width and output-count functions.
REQ-037 One sub-module, conv_window_buf, shall hold K_SIZE-1 line buffers of IMG_W entries plus the K_SIZE x K_SIZE window registers.

Verification
REQ-038 IMG 4x4, K=3, S=1, centre weight 1<<Q, all others 0, pixels 0..15 -> outputs 5,6,9,10; out_last on 10; done 1 cycle after it is accepted.
REQ-039 Same frame with out_ready low for 3 cycles on each output -> identical values; in_ready=0 while stalled; no pixel lost.
REQ-040 IMG 5x5, K=3, S=2, all weights 1<<Q, all pixels 1<<Q -> 4 outputs, each 9<<Q.
REQ-041 All weights and pixels 0x7FFF (Q=5) -> every output 0x7FFF; all 0x8000 weights with 0x7FFF pixels -> 0x8000.
REQ-042 rst=0 after 7 pixels accepted, then new frame -> no stale outputs; second frame results match a clean run.
REQ-043 start and w_we asserted during RUN -> ignored; results match the weights loaded before start.
